// File: rtl/muldiv_sched.sv
// Sequencing controller for the EX-stage multiply/divide unit; owns HI/LO.
// Optional MADD/MSUB accumulate support is enabled by defining MULTDIV_ACC_EN.
//
// Handshake: an operation is issued in the IDLE cycle where op_valid carries an
// MD function code. md_funct/md_op* are held until the one-cycle md_done pulse.
// stall_req is held high until then, so EX keeps the instruction in place.
module muldiv_sched #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_in,
  input  logic        op_valid,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic [5:0]  md_funct,
  output logic [31:0] md_op1,
  output logic [31:0] md_op2,
  input  logic        md_done,
  input  logic [63:0] md_result,
`ifdef MULTDIV_ACC_EN
  input  logic [1:0]  acc_mode,
`endif
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout_err,
  output logic [1:0]  fsm_state
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt;
  logic [5:0]  funct_q;
  logic [31:0] op1_q, op2_q;
  logic        is_md, issue, wd_hit, commit;
  logic        mthi_wr, mtlo_wr;
  logic [63:0] commit_val;
`ifdef MULTDIV_ACC_EN
  logic [1:0]  acc_q;
`endif

  assign fsm_state = state;

  always_comb begin
    is_md   = (funct == F_MULT) || (funct == F_MULTU) ||
              (funct == F_DIV)  || (funct == F_DIVU);
    issue   = (state == S_IDLE) && op_valid && is_md;
    wd_hit  = (state == S_BUSY) && !md_done && (cnt == CW'(TIMEOUT - 1));
    commit  = (state == S_BUSY) && md_done && !flush;
    mthi_wr = (state == S_IDLE) && op_valid && !stall_in && (funct == F_MTHI) && !flush;
    mtlo_wr = (state == S_IDLE) && op_valid && !stall_in && (funct == F_MTLO) && !flush;
  end

  // Next state; flush overrides everything, including a same-cycle md_done.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (issue) state_nxt = S_BUSY;
      S_BUSY: begin
        if (md_done)     state_nxt = stall_in ? S_HOLD : S_IDLE;
        else if (wd_hit) state_nxt = S_IDLE;
      end
      S_HOLD: if (!stall_in) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Unit drive and stall; the stall also drops in the watchdog cycle so the
  // aborted instruction leaves EX at the same edge the FSM returns to IDLE.
  always_comb begin
    md_funct = 6'd0;
    md_op1   = 32'd0;
    md_op2   = 32'd0;
    if (issue) begin
      md_funct = funct;
      md_op1   = operand_1;
      md_op2   = operand_2;
    end else if (state == S_BUSY) begin
      md_funct = funct_q;
      md_op1   = op1_q;
      md_op2   = op2_q;
    end
    stall_req = issue || ((state == S_BUSY) && !md_done && !wd_hit);
  end

  always_comb begin
    commit_val = md_result;
`ifdef MULTDIV_ACC_EN
    if ((funct_q == F_MULT) || (funct_q == F_MULTU)) begin
      case (acc_q)
        2'b01:   commit_val = {hi, lo} + md_result;
        2'b10:   commit_val = {hi, lo} - md_result;
        default: commit_val = md_result;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      funct_q     <= 6'd0;
      op1_q       <= 32'd0;
      op2_q       <= 32'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      timeout_err <= 1'b0;
`ifdef MULTDIV_ACC_EN
      acc_q       <= 2'b00;
`endif
    end else begin
      state <= state_nxt;
      if (!flush && (state == S_BUSY) && !md_done && !wd_hit)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      if (issue && !flush) begin
        funct_q <= funct;
        op1_q   <= operand_1;
        op2_q   <= operand_2;
`ifdef MULTDIV_ACC_EN
        acc_q   <= acc_mode;
`endif
      end
      if (commit) begin
        hi <= commit_val[63:32];
        lo <= commit_val[31:0];
      end else begin
        if (mthi_wr) hi <= operand_1;
        if (mtlo_wr) lo <= operand_1;
      end
      if (wd_hit && !flush) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched; the bench itself plays the multiply/divide unit.
module tb_muldiv_sched;

  logic        clk, rst, flush, stall_in, op_valid, md_done;
  logic [5:0]  funct, md_funct;
  logic [31:0] operand_1, operand_2, md_op1, md_op2, hi, lo;
  logic [63:0] md_result;
  logic        stall_req, timeout_err;
  logic [1:0]  fsm_state;
  logic [1:0]  acc_mode;

  int total = 0;
  int bad   = 0;

  muldiv_sched #(.TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
    .op_valid(op_valid), .funct(funct),
    .operand_1(operand_1), .operand_2(operand_2),
    .md_funct(md_funct), .md_op1(md_op1), .md_op2(md_op2),
    .md_done(md_done), .md_result(md_result),
`ifdef MULTDIV_ACC_EN
    .acc_mode(acc_mode),
`endif
    .stall_req(stall_req), .hi(hi), .lo(lo),
    .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;   // 0: no unit operation
    logic [63:0] res;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // MD operation with the unit's done pulse after lat cycles; hold>0 keeps
  // stall_in high from the done cycle for hold cycles of HOLD.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] res, input int hold,
                        input logic [63:0] exp);
    int sc;
    sc = 0;
    tick();
    op_valid = 1'b1; funct = f; operand_1 = a; operand_2 = b;
    md_done = 1'b0; stall_in = 1'b0;
    #1;
    chk("issue_drive", {md_funct, md_op1, md_op2}, {f, a, b});
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) tick();
      if (k == lat) begin
        md_done = 1'b1; md_result = res; stall_in = (hold > 0);
        #1;
      end
      if (stall_req) sc++;
      if (k == 1) chk("busy_drive", {md_funct, md_op1, md_op2}, {f, a, b});
    end
    tick();
    md_done = 1'b0; md_result = ~res;
    if (hold == 0) op_valid = 1'b0;
    else begin
      for (int k = 0; k < hold; k++) begin
        #1;
        chk("hold_state", {fsm_state, md_funct, stall_req}, {2'd2, 6'd0, 1'b0});
        tick();
      end
      stall_in = 1'b0;
      #1;
      chk("hold_release", {fsm_state, md_funct}, {2'd2, 6'd0});
      tick();
      op_valid = 1'b0;
    end
    #1;
    chk("stall_cycles", sc, lat);
    chk("hilo", {hi, lo}, exp);
    chk("idle_after", {fsm_state, stall_req}, {2'd0, 1'b0});
  endtask

  task automatic run_mt(input logic [5:0] f, input logic [31:0] a, input logic [63:0] exp);
    tick();
    op_valid = 1'b1; funct = f; operand_1 = a; stall_in = 1'b0;
    #1;
    chk("mt_nostall", {stall_req, md_funct}, {1'b0, 6'd0});
    tick();
    op_valid = 1'b0;
    #1;
    chk("mt_hilo", {hi, lo}, exp);
  endtask

  initial begin
    int n;
    logic [63:0] saved;

    rst = 1'b1; flush = 1'b0; stall_in = 1'b0; op_valid = 1'b0; funct = 6'd0;
    operand_1 = 32'd0; operand_2 = 32'd0; md_done = 1'b0; md_result = 64'd0;
    acc_mode = 2'b00;

    vecs[0] = '{6'h18, 32'hFFFFFFFF, 32'h2, 2,  64'hFFFFFFFF_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFE};
    vecs[1] = '{6'h1b, 32'd100,      32'd7, 34, 64'h00000002_0000000E, 64'h00000002_0000000E};
    vecs[2] = '{6'h11, 32'h1234,     32'h0, 0,  64'h0,                 64'h00001234_0000000E};
    vecs[3] = '{6'h13, 32'h5678,     32'h0, 0,  64'h0,                 64'h00001234_00005678};
    vecs[4] = '{6'h20, 32'hDEAD,     32'h1, 0,  64'h0,                 64'h00001234_00005678};
    vecs[5] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 64'hFFFFFFFE_00000001, 64'hFFFFFFFE_00000001};
    vecs[6] = '{6'h1a, 32'hFFFFFFF9, 32'h2, 34, 64'hFFFFFFFF_FFFFFFFD, 64'hFFFFFFFF_FFFFFFFD};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset", {hi, lo, timeout_err, stall_req, md_funct, fsm_state},
         {32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 2'd0});

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].lat > 0)
        run_md(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].res, 0, vecs[i].exp);
      else
        run_mt(vecs[i].f, vecs[i].a, vecs[i].exp);
    end

    // DIV completing while stall_in is held: one write, then HOLD until release.
    run_md(6'h1b, 32'd50, 32'd8, 34, 64'h00000002_00000006, 5, 64'h00000002_00000006);

    // MTHI/MTLO back to back, then an MTHI blocked by stall_in.
    tick();
    op_valid = 1'b1; funct = 6'h11; operand_1 = 32'hAAAA_0001;
    tick();
    funct = 6'h13; operand_1 = 32'hBBBB_0002;
    #1;
    chk("b2b_hi", {hi, stall_req}, {32'hAAAA_0001, 1'b0});
    tick();
    funct = 6'h11; operand_1 = 32'hCCCC_0003; stall_in = 1'b1;
    #1;
    chk("b2b_lo", {lo, stall_req}, {32'hBBBB_0002, 1'b0});
    tick();
    op_valid = 1'b0; stall_in = 1'b0;
    #1;
    chk("mthi_stalled", hi, 32'hAAAA_0001);

    // Flush at T+10 of a DIV, then a normal MULT.
    saved = {hi, lo};
    tick();
    op_valid = 1'b1; funct = 6'h1a; operand_1 = 32'd9; operand_2 = 32'd3;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("flush_idle", {fsm_state, stall_req, hi, lo}, {2'd0, 1'b0, saved});
    run_md(6'h18, 32'd6, 32'd7, 2, 64'd42, 0, 64'd42);

    // Watchdog: md_done never arrives.
    saved = {hi, lo};
    tick();
    op_valid = 1'b1; funct = 6'h1b; operand_1 = 32'd1; operand_2 = 32'd0;
    n = 0;
    while (!timeout_err && n < 100) begin
      logic was_stall;
      #1;
      was_stall = stall_req;
      tick();
      n++;
      if (!was_stall) op_valid = 1'b0;
    end
    #1;
    chk("wd_cycle", n, 41);
    chk("wd_after", {timeout_err, stall_req, fsm_state, hi, lo}, {1'b1, 1'b0, 2'd0, saved});
    repeat (5) tick();
    chk("wd_sticky", timeout_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("wd_cleared", {timeout_err, hi, lo}, {1'b0, 64'd0});

`ifdef MULTDIV_ACC_EN
    run_mt(6'h13, 32'd10, 64'd10);
    acc_mode = 2'b01;
    run_md(6'h18, 32'd3, 32'd4, 2, 64'd12, 0, 64'd22);
    acc_mode = 2'b10;
    run_md(6'h18, 32'd5, 32'd6, 2, 64'd30, 0, 64'hFFFFFFFF_FFFFFFF8);
    acc_mode = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
